// File: rtl/m_reg_bank.sv
// Bank of DEPTH x WIDTH registers: one operate-style write port, two registered read ports.
// Define M_REG_BANK_BYPASS_EN to forward a same-cycle write result to the read ports.
module m_reg_bank #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [2:0]       wr_op,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             serial_in,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             wrap,
  output logic             addr_err
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_INC  = 3'd4,
    OP_DEC  = 3'd5,
    OP_CLR  = 3'd6,
    OP_OR   = 3'd7
  } op_e;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];

  logic             wr_vld_p0;
  logic             wr_chg_p0;
  logic [WIDTH-1:0] wr_old_p0;
  logic [WIDTH-1:0] wr_new_p0;
  logic             wrap_p0;
  logic [WIDTH-1:0] rd_a_p0;
  logic [WIDTH-1:0] rd_b_p0;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  // Address decode by comparison so non-power-of-2 depths never index past the array.
  function automatic logic [WIDTH-1:0] reg_at(input logic [AW-1:0] a);
    logic [WIDTH-1:0] res;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a == AW'(i)) res = regs[i];
    end
    return res;
  endfunction

  // Returns {wrap, new_value}; wrap flags a modular roll-over or a shifted-out one.
  function automatic logic [WIDTH:0] apply_op(input logic [2:0] op,
                                              input logic [WIDTH-1:0] r,
                                              input logic [WIDTH-1:0] d,
                                              input logic si);
    logic [WIDTH:0] res;
    case (op_e'(op))
      OP_LOAD: res = {1'b0, d};
      OP_SHL:  res = {r[WIDTH-1], r[WIDTH-2:0], si};
      OP_SHR:  res = {r[0], si, r[WIDTH-1:1]};
      OP_INC:  res = {&r, r + WIDTH'(1)};
      OP_DEC:  res = {~|r, r - WIDTH'(1)};
      OP_CLR:  res = '0;
      OP_OR:   res = {1'b0, r | d};
      default: res = {1'b0, r};
    endcase
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] rd_next(input logic [AW-1:0] a);
`ifdef M_REG_BANK_BYPASS_EN
    if (wr_chg_p0 && (a == wr_addr)) return wr_new_p0;
`endif
    return reg_at(a);
  endfunction

  // p0: combinational operate and read selection
  always_comb begin
    wr_vld_p0 = wr_en && addr_ok(wr_addr);
    wr_chg_p0 = wr_vld_p0 && (wr_op != OP_HOLD);
    wr_old_p0 = reg_at(wr_addr);
    {wrap_p0, wr_new_p0} = apply_op(wr_op, wr_old_p0, wr_data, serial_in);
    rd_a_p0   = rd_next(rd_addr_a);
    rd_b_p0   = rd_next(rd_addr_b);
  end

  // p1: register bank update and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
      rd_data_a <= '0;
      rd_data_b <= '0;
      wrap      <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_chg_p0 && (wr_addr == AW'(i))) regs[i] <= wr_new_p0;
      end
      rd_data_a <= rd_a_p0;
      rd_data_b <= rd_b_p0;
      wrap      <= wr_vld_p0 && wrap_p0;
      addr_err  <= wr_en && !addr_ok(wr_addr);
    end
  end

endmodule
